// File: rtl/writeback_controller.sv
// Writeback arbiter: merges scalar and vector pipeline writes onto the scalar and vector register-file ports.
// Latency: one cycle from the request to the registered write-port outputs.
// Backpressure: none. A stalled scalar request is re-presented upstream; dropped or illegal requests raise sticky wb_error.

// One writeback path: a one-entry holding buffer plus the port arbiter for one register file.
// Latency: one cycle, because wr_en/wr_addr/wr_data are registered.
// Backpressure: none. err and drain are single-cycle pulses that the top level accumulates.
module writeback_path #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_wr_en,
    input  logic [4:0]   s_addr,
    input  logic [W-1:0] s_data,
    input  logic         v_wr_en,
    input  logic [4:0]   v_addr,
    input  logic [W-1:0] v_data,
    input  logic         wb_sel,
    input  logic         buf_cap,
    input  logic         buf_sel,
    output logic         wr_en,
    output logic [4:0]   wr_addr,
    output logic [W-1:0] wr_data,
    output logic         err,
    output logic         drain
);

    typedef enum logic {EMPTY = 1'b0, HELD = 1'b1} buf_state_t;

    buf_state_t   state, state_nxt;
    logic [4:0]   buf_addr;
    logic [W-1:0] buf_data;
    logic         sel_wr;
    logic [4:0]   sel_addr;
    logic [W-1:0] sel_data;

    // Buffer state register: a capture always wins and overwrites; a drain with no capture empties the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            buf_addr <= '0;
            buf_data <= '0;
        end else begin
            state <= state_nxt;
            if (buf_cap) begin
                buf_addr <= v_addr;
                buf_data <= v_data;
            end
        end
    end

    // Next state, port arbitration (buffer drain > vector owner > scalar) and protocol-error detection.
    always_comb begin
        state_nxt = state;
        sel_wr    = 1'b0;
        sel_addr  = wr_addr;
        sel_data  = wr_data;
        drain     = buf_sel && (state == HELD);
        err       = 1'b0;

        if (drain) begin
            sel_wr   = 1'b1;
            sel_addr = buf_addr;
            sel_data = buf_data;
        end else if (wb_sel && v_wr_en) begin
            sel_wr   = 1'b1;
            sel_addr = v_addr;
            sel_data = v_data;
        end else if (s_wr_en) begin
            sel_wr   = 1'b1;
            sel_addr = s_addr;
            sel_data = s_data;
        end

        // Draining an empty buffer is illegal. A scalar write displaced by a drain is lost,
        // whereas one displaced by the vector owner is only a stall. Capturing while the
        // vector pipeline owns the port is illegal.
        if (buf_sel && (state == EMPTY)) err = 1'b1;
        if (drain && s_wr_en)            err = 1'b1;
        if (buf_cap && wb_sel)           err = 1'b1;

        if (buf_cap)    state_nxt = HELD;
        else if (drain) state_nxt = EMPTY;
    end

    // Registered write port; address and data keep their last values on idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en   <= sel_wr;
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end
    end

endmodule

module writeback_controller #(
    parameter int DATA_W = 32,
    parameter int VEC_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_reg_wr_en,
    input  logic [4:0]        s_reg_addr,
    input  logic [DATA_W-1:0] s_reg_data,
    input  logic              s_vec_wr_en,
    input  logic [4:0]        s_vec_addr,
    input  logic [VEC_W-1:0]  s_vec_data,
    input  logic              v_reg_wr_en,
    input  logic [4:0]        v_reg_addr,
    input  logic [DATA_W-1:0] v_reg_data,
    input  logic              v_vec_wr_en,
    input  logic [4:0]        v_vec_addr,
    input  logic [VEC_W-1:0]  v_vec_data,
    input  logic              register_wb_sel,
    input  logic              vector_wb_sel,
    input  logic              buffer_register,
    input  logic              buffer_vector,
    input  logic              buffer_register_sel,
    input  logic              buffer_vector_sel,
    output logic              rf_wr_en,
    output logic [4:0]        rf_wr_addr,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              vf_wr_en,
    output logic [4:0]        vf_wr_addr,
    output logic [VEC_W-1:0]  vf_wr_data,
    output logic              wb_error,
    output logic [7:0]        buffered_wr_cnt
);

    logic       reg_err, vec_err;
    logic       reg_drain, vec_drain;
    logic [8:0] cnt_sum;

    writeback_path #(.W(DATA_W)) u_reg_path (
        .clk     (clk),
        .rst     (rst),
        .s_wr_en (s_reg_wr_en),
        .s_addr  (s_reg_addr),
        .s_data  (s_reg_data),
        .v_wr_en (v_reg_wr_en),
        .v_addr  (v_reg_addr),
        .v_data  (v_reg_data),
        .wb_sel  (register_wb_sel),
        .buf_cap (buffer_register),
        .buf_sel (buffer_register_sel),
        .wr_en   (rf_wr_en),
        .wr_addr (rf_wr_addr),
        .wr_data (rf_wr_data),
        .err     (reg_err),
        .drain   (reg_drain)
    );

    writeback_path #(.W(VEC_W)) u_vec_path (
        .clk     (clk),
        .rst     (rst),
        .s_wr_en (s_vec_wr_en),
        .s_addr  (s_vec_addr),
        .s_data  (s_vec_data),
        .v_wr_en (v_vec_wr_en),
        .v_addr  (v_vec_addr),
        .v_data  (v_vec_data),
        .wb_sel  (vector_wb_sel),
        .buf_cap (buffer_vector),
        .buf_sel (buffer_vector_sel),
        .wr_en   (vf_wr_en),
        .wr_addr (vf_wr_addr),
        .wr_data (vf_wr_data),
        .err     (vec_err),
        .drain   (vec_drain)
    );

    // The sum is widened to nine bits so that an overflow past 255 can be detected and clamped.
    always_comb begin
        cnt_sum = {1'b0, buffered_wr_cnt} + {8'd0, reg_drain} + {8'd0, vec_drain};
    end

    // Sticky error flag and saturating drain counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_error        <= 1'b0;
            buffered_wr_cnt <= 8'd0;
        end else begin
            if (reg_err || vec_err) wb_error <= 1'b1;
            buffered_wr_cnt <= cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
        end
    end

endmodule

// File: tb/tb_writeback_controller.sv
module tb_writeback_controller;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_reg_wr_en, s_vec_wr_en, v_reg_wr_en, v_vec_wr_en;
    logic [4:0]   s_reg_addr, s_vec_addr, v_reg_addr, v_vec_addr;
    logic [31:0]  s_reg_data, v_reg_data;
    logic [127:0] s_vec_data, v_vec_data;
    logic         register_wb_sel, vector_wb_sel;
    logic         buffer_register, buffer_vector;
    logic         buffer_register_sel, buffer_vector_sel;
    logic         rf_wr_en, vf_wr_en, wb_error;
    logic [4:0]   rf_wr_addr, vf_wr_addr;
    logic [31:0]  rf_wr_data;
    logic [127:0] vf_wr_data;
    logic [7:0]   buffered_wr_cnt;

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] VDAT_A = 128'hDEAD_BEEF_0000_0001_1234_5678_9ABC_DEF0;
    localparam logic [127:0] VDAT_B = 128'h0BAD_F00D_5555_AAAA_0000_FFFF_1111_2222;

    writeback_controller #(.DATA_W(32), .VEC_W(128)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s_reg_wr_en         (s_reg_wr_en),
        .s_reg_addr          (s_reg_addr),
        .s_reg_data          (s_reg_data),
        .s_vec_wr_en         (s_vec_wr_en),
        .s_vec_addr          (s_vec_addr),
        .s_vec_data          (s_vec_data),
        .v_reg_wr_en         (v_reg_wr_en),
        .v_reg_addr          (v_reg_addr),
        .v_reg_data          (v_reg_data),
        .v_vec_wr_en         (v_vec_wr_en),
        .v_vec_addr          (v_vec_addr),
        .v_vec_data          (v_vec_data),
        .register_wb_sel     (register_wb_sel),
        .vector_wb_sel       (vector_wb_sel),
        .buffer_register     (buffer_register),
        .buffer_vector       (buffer_vector),
        .buffer_register_sel (buffer_register_sel),
        .buffer_vector_sel   (buffer_vector_sel),
        .rf_wr_en            (rf_wr_en),
        .rf_wr_addr          (rf_wr_addr),
        .rf_wr_data          (rf_wr_data),
        .vf_wr_en            (vf_wr_en),
        .vf_wr_addr          (vf_wr_addr),
        .vf_wr_data          (vf_wr_data),
        .wb_error            (wb_error),
        .buffered_wr_cnt     (buffered_wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        s_reg_wr_en = 0; s_vec_wr_en = 0; v_reg_wr_en = 0; v_vec_wr_en = 0;
        s_reg_addr = 0; s_vec_addr = 0; v_reg_addr = 0; v_vec_addr = 0;
        s_reg_data = 0; s_vec_data = 0; v_reg_data = 0; v_vec_data = 0;
        register_wb_sel = 0; vector_wb_sel = 0;
        buffer_register = 0; buffer_vector = 0;
        buffer_register_sel = 0; buffer_vector_sel = 0;
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        #2;
        check("reset_rf_wr_en", rf_wr_en, 0);
        check("reset_vf_wr_en", vf_wr_en, 0);
        check("reset_wb_error", wb_error, 0);
        check("reset_cnt", buffered_wr_cnt, 0);
        step();
        rst = 1'b0;
        step();

        // Scalar-only write.
        s_reg_wr_en = 1; s_reg_addr = 3; s_reg_data = 32'hAA;
        step();
        check("scalar_en", rf_wr_en, 1);
        check("scalar_addr", rf_wr_addr, 3);
        check("scalar_data", rf_wr_data, 32'hAA);
        check("scalar_err", wb_error, 0);
        idle();
        step();
        check("idle_en", rf_wr_en, 0);
        check("idle_addr_hold", rf_wr_addr, 3);
        check("idle_data_hold", rf_wr_data, 32'hAA);

        // Capture into the register buffer while the scalar write goes through, then drain.
        buffer_register = 1; v_reg_addr = 5; v_reg_data = 32'h11;
        s_reg_wr_en = 1; s_reg_addr = 5; s_reg_data = 32'h22;
        step();
        check("bufseq_c1_en", rf_wr_en, 1);
        check("bufseq_c1_data", rf_wr_data, 32'h22);
        idle();
        buffer_register_sel = 1;
        step();
        check("bufseq_c2_en", rf_wr_en, 1);
        check("bufseq_c2_addr", rf_wr_addr, 5);
        check("bufseq_c2_data", rf_wr_data, 32'h11);
        check("bufseq_cnt", buffered_wr_cnt, 1);
        check("bufseq_err", wb_error, 0);
        idle();

        // The vector pipeline owns the vector port; the scalar vector request stalls.
        vector_wb_sel = 1; v_vec_wr_en = 1; v_vec_addr = 7; v_vec_data = VDAT_A;
        s_vec_wr_en = 1; s_vec_addr = 9; s_vec_data = VDAT_B;
        step();
        check("vown_en", vf_wr_en, 1);
        check("vown_addr", vf_wr_addr, 7);
        check("vown_data", vf_wr_data, VDAT_A);
        check("vown_rf_idle", rf_wr_en, 0);
        check("vown_err", wb_error, 0);
        idle();

        // Fill both buffers without writing anything to the ports.
        buffer_register = 1; v_reg_addr = 2; v_reg_data = 32'h2;
        buffer_vector = 1; v_vec_addr = 6; v_vec_data = VDAT_B;
        step();
        check("cap_both_rf_idle", rf_wr_en, 0);
        check("cap_both_vf_idle", vf_wr_en, 0);
        idle();
        // Drain both buffers while recapturing the register buffer in the same cycle.
        buffer_register = 1; v_reg_addr = 4; v_reg_data = 32'h4;
        buffer_register_sel = 1; buffer_vector_sel = 1;
        step();
        check("dc_rf_addr_old", rf_wr_addr, 2);
        check("dc_rf_data_old", rf_wr_data, 32'h2);
        check("dc_vf_en", vf_wr_en, 1);
        check("dc_vf_addr", vf_wr_addr, 6);
        check("dc_vf_data", vf_wr_data, VDAT_B);
        check("dc_cnt_plus2", buffered_wr_cnt, 3);
        idle();
        buffer_register_sel = 1;
        step();
        check("dc_rf_en_new", rf_wr_en, 1);
        check("dc_rf_addr_new", rf_wr_addr, 4);
        check("dc_vf_idle", vf_wr_en, 0);
        check("dc_cnt", buffered_wr_cnt, 4);
        check("dc_err", wb_error, 0);
        idle();

        // Saturation: one capture, 252 capture+drain cycles, then a final drain.
        buffer_register = 1; v_reg_addr = 1; v_reg_data = 32'h100;
        step();
        for (int i = 0; i < 252; i++) begin
            buffer_register = 1; buffer_register_sel = 1;
            v_reg_addr = 5'(i % 32); v_reg_data = 32'(i);
            step();
        end
        check("sat_cnt", buffered_wr_cnt, 255);
        idle();
        buffer_register_sel = 1;
        step();
        check("sat_last_en", rf_wr_en, 1);
        check("sat_last_data", rf_wr_data, 32'd251);
        check("sat_cnt_hold", buffered_wr_cnt, 255);
        check("sat_err", wb_error, 0);
        idle();

        // Draining an empty vector buffer is an error, and the flag is sticky.
        buffer_vector_sel = 1;
        step();
        check("empty_drain_vf", vf_wr_en, 0);
        check("empty_drain_err", wb_error, 1);
        idle();
        step();
        step();
        check("err_sticky", wb_error, 1);

        // Asynchronous reset while a buffer is held: outputs clear at once, and the buffer is lost.
        s_reg_wr_en = 1; s_reg_addr = 12; s_reg_data = 32'h55;
        buffer_register = 1; v_reg_addr = 9; v_reg_data = 32'h99;
        step();
        idle();
        check("pre_rst_en", rf_wr_en, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_en", rf_wr_en, 0);
        check("async_rst_addr", rf_wr_addr, 0);
        check("async_rst_data", rf_wr_data, 0);
        check("async_rst_err", wb_error, 0);
        check("async_rst_cnt", buffered_wr_cnt, 0);
        step();
        rst = 1'b0;
        buffer_register_sel = 1;
        step();
        check("post_rst_no_write", rf_wr_en, 0);
        check("post_rst_err", wb_error, 1);
        idle();

        // A register-port vector owner stalls the scalar request without an error.
        do_reset();
        register_wb_sel = 1; v_reg_wr_en = 1; v_reg_addr = 8; v_reg_data = 32'h88;
        s_reg_wr_en = 1; s_reg_addr = 10; s_reg_data = 32'hA0;
        step();
        check("stall_addr", rf_wr_addr, 8);
        check("stall_err", wb_error, 0);
        idle();
        // A scalar request displaced by a buffer drain is dropped, which is an error.
        buffer_register = 1; v_reg_addr = 13; v_reg_data = 32'hD0;
        step();
        idle();
        buffer_register_sel = 1;
        s_reg_wr_en = 1; s_reg_addr = 14; s_reg_data = 32'hE0;
        step();
        check("drop_addr", rf_wr_addr, 13);
        check("drop_err", wb_error, 1);
        idle();

        // Capture while the vector pipeline owns the port: error, but the write and the capture both happen.
        do_reset();
        buffer_vector = 1; vector_wb_sel = 1; v_vec_wr_en = 1;
        v_vec_addr = 3; v_vec_data = VDAT_A;
        step();
        check("capsel_vf_addr", vf_wr_addr, 3);
        check("capsel_err", wb_error, 1);
        idle();
        buffer_vector_sel = 1;
        step();
        check("capsel_drain_en", vf_wr_en, 1);
        check("capsel_drain_data", vf_wr_data, VDAT_A);
        check("capsel_cnt", buffered_wr_cnt, 1);
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_controller.md
WRITEBACK_CONTROLLER -- requirements
Module: writeback_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 32, scalar register data width.
REQ-002 SHALL have parameter VEC_W, default 128, vector register data width (4 lanes x 32).
REQ-003 SHALL have port clk, input, 1, clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have ports s_reg_wr_en/s_reg_addr/s_reg_data, input, 1/5/DATA_W, scalar-pipeline (mem stage) register write request.
REQ-006 SHALL have ports s_vec_wr_en/s_vec_addr/s_vec_data, input, 1/5/VEC_W, scalar-pipeline vector write request.
REQ-007 SHALL have ports v_reg_wr_en/v_reg_addr/v_reg_data, input, 1/5/DATA_W, vector-pipeline final-stage register write request.
REQ-008 SHALL have ports v_vec_wr_en/v_vec_addr/v_vec_data, input, 1/5/VEC_W, vector-pipeline final-stage vector write request.
REQ-009 SHALL have ports register_wb_sel, vector_wb_sel, input, 1 each; vector pipeline owns that writeback port this cycle.
REQ-010 SHALL have ports buffer_register, buffer_vector, input, 1 each; capture the vector-pipeline result into the buffer this cycle.
REQ-011 SHALL have ports buffer_register_sel, buffer_vector_sel, input, 1 each; drain the held buffer to the port this cycle.
REQ-012 SHALL have ports rf_wr_en/rf_wr_addr/rf_wr_data, output, 1/5/DATA_W, registered scalar register-file write port.
REQ-013 SHALL have ports vf_wr_en/vf_wr_addr/vf_wr_data, output, 1/5/VEC_W, registered vector register-file write port.
REQ-014 SHALL have port wb_error, output, 1, sticky protocol-violation flag.
REQ-015 SHALL have port buffered_wr_cnt, output, 8, saturating count of buffered writes drained (both files).

Function
REQ-016 Register path and vector path SHALL be identical, independent instances of REQ-017..REQ-024 (names substituted: reg<->vec, rf<->vf).
REQ-017 Each path SHALL hold a one-entry buffer (addr, data) with a two-state FSM: EMPTY, HELD.
REQ-018 Port arbitration in cycle N, priority order: (1) buffer_*_sel & HELD -> buffer contents; (2) *_wb_sel & v_*_wr_en -> vector-pipeline request; (3) s_*_wr_en -> scalar request; (4) none -> no write.
REQ-019 Selected write SHALL appear on the rf/vf port at cycle N+1 (one-cycle registered latency); wr_en low with addr/data holding last values when no write.
REQ-020 buffer_* asserted SHALL capture v_*_addr/v_*_data at the edge ending cycle N; FSM -> HELD, regardless of prior state (overwrite).
REQ-021 buffer_*_sel in HELD without buffer_* SHALL drain and move to EMPTY; with buffer_* in the same cycle SHALL drain old contents, capture new, stay HELD.
REQ-022 buffer_*_sel in EMPTY SHALL produce no write and SHALL set wb_error.
REQ-023 Scalar request losing arbitration only to priority (2) is a normal stall (re-presented upstream), no error; losing to priority (1) SHALL set wb_error (dropped write).
REQ-024 buffer_* and *_wb_sel both high in one cycle SHALL set wb_error; capture still occurs, port still serves priority (2).
REQ-025 buffered_wr_cnt SHALL increment by the number of drains per cycle (0, 1 or 2), saturating at 255.
REQ-026 wb_error SHALL remain set until reset.

Reset
REQ-027 rst asserted SHALL immediately clear rf_wr_en, vf_wr_en, all addr/data outputs to 0, both FSMs to EMPTY, buffers to 0, wb_error to 0, buffered_wr_cnt to 0.
REQ-028 A HELD buffer at reset SHALL be discarded without a write after rst deasserts.

Verification
REQ-029 Scalar only: s_reg_wr_en=1, addr 3, data 0xAA at cycle 0 -> rf_wr_en=1, addr 3, data 0xAA at cycle 1; no error.
REQ-030 Buffer sequence: cycle 0 buffer_register=1, v_reg addr 5 data 0x11, s_reg addr 5 data 0x22 -> cycle 1 rf writes 5/0x22; cycle 1 buffer_register_sel=1 -> cycle 2 rf writes 5/0x11; buffered_wr_cnt=1.
REQ-031 Vector ownership: vector_wb_sel=1, v_vec addr 7, s_vec_wr_en=1 addr 9 -> next cycle vf writes addr 7 only; wb_error stays 0.
REQ-032 Error: buffer_vector_sel=1 with vector buffer EMPTY -> no vf write, wb_error=1 and remains 1 until rst.
REQ-033 Simultaneous drain+capture: HELD addr 2, cycle N buffer_register=1 (addr 4) and buffer_register_sel=1 -> N+1 writes addr 2; N+1 sel -> N+2 writes addr 4; counter 255 stays 255.
REQ-034 Reset mid-operation: HELD buffer, rst pulsed asynchronously -> outputs 0 immediately; subsequent buffer_register_sel sets wb_error, no write.
